// File: rtl/prbs_wide_check_pkg.sv
// Shared definitions for the wide PRBS checker: state encoding and the
// per-word LFSR step used by both generator and checker.
package prbs_wide_check_pkg;

  localparam int MAX_W = 64;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // One generator word step: width single-bit shifts of the Fibonacci LFSR.
  // Bits above width are don't-care; callers keep only the low width bits.
  function automatic logic [MAX_W-1:0] advance(input logic [MAX_W-1:0] x,
                                               input int width,
                                               input int tap1,
                                               input int tap2);
    logic [MAX_W-1:0] s;
    s = x;
    for (int i = 0; i < width; i++) begin
      s = {s[MAX_W-2:0], s[tap1[5:0]] ^ s[tap2[5:0]]};
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs_wide_check_popcount.sv
// Combinational population count of a WIDTH-bit word.
module prbs_popcount #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_data[i]);
    end
  end

endmodule

// File: rtl/prbs_wide_check.sv
// Receive-side PRBS checker: self-synchronising reference, lock tracking
// and saturating bit-error / bit-total counters for BER measurement.
module prbs_wide_check
  import prbs_wide_check_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TAP1       = 6,
  parameter int TAP2       = 5,
  parameter int CNT_W      = 32,
  parameter int LOCK_WORDS = 4,
  parameter int LOSS_WORDS = 4,
  parameter int LOSS_BITS  = WIDTH / 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clear,
  output logic                       locked,
  output logic                       err_word,
  output logic [$clog2(WIDTH+1)-1:0] err_bits,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_WORDS + 1);
  localparam int LW = $clog2(LOSS_WORDS + 1);
  localparam logic [CW-1:0] LOSS_LIM  = CW'(LOSS_BITS);
  localparam logic [MW-1:0] LOCK_CNT  = MW'(LOCK_WORDS);
  localparam logic [LW-1:0] LOSS_CNT  = LW'(LOSS_WORDS);

  state_t           r_state;
  logic [WIDTH-1:0] r_ref;
  logic [MW-1:0]    r_matchCnt;
  logic [LW-1:0]    r_lossCnt;
  logic             r_locked;
  logic             r_errWord;
  logic [CW-1:0]    r_errBits;
  logic [CNT_W-1:0] r_errCnt;
  logic [CNT_W-1:0] r_bitCnt;

  logic [WIDTH-1:0] w_nextFromData;
  logic [WIDTH-1:0] w_nextFromRef;
  logic [WIDTH-1:0] w_diff;
  logic [CW-1:0]    w_errBits;
  logic             w_match;
  logic             w_bad;
  logic [MW-1:0]    w_matchNext;
  logic [LW-1:0]    w_lossNext;
  logic [CNT_W:0]   w_errSum;
  logic [CNT_W:0]   w_bitSum;

  assign w_nextFromData = WIDTH'(advance(MAX_W'(data_in), WIDTH, TAP1, TAP2));
  assign w_nextFromRef  = WIDTH'(advance(MAX_W'(r_ref), WIDTH, TAP1, TAP2));
  assign w_diff         = data_in ^ r_ref;

  prbs_popcount #(.WIDTH(WIDTH), .CW(CW)) u_popcount (
    .i_data  (w_diff),
    .o_count (w_errBits)
  );

  // All-zero words are the LFSR lock-up state and must never count as a match.
  assign w_match     = (data_in == r_ref) && (|data_in);
  assign w_bad       = w_errBits > LOSS_LIM;
  assign w_matchNext = r_matchCnt + 1'b1;
  assign w_lossNext  = r_lossCnt + 1'b1;
  assign w_errSum    = {1'b0, r_errCnt} + (CNT_W+1)'(w_errBits);
  assign w_bitSum    = {1'b0, r_bitCnt} + (CNT_W+1)'(WIDTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_HUNT;
      r_ref      <= '0;
      r_matchCnt <= '0;
      r_lossCnt  <= '0;
      r_locked   <= 1'b0;
      r_errWord  <= 1'b0;
      r_errBits  <= '0;
    end else if (en) begin
      case (r_state)
        ST_HUNT: begin
          r_ref     <= w_nextFromData;
          r_errWord <= 1'b0;
          if (w_match) begin
            if (w_matchNext == LOCK_CNT) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_matchCnt <= '0;
              r_lossCnt  <= '0;
            end else begin
              r_matchCnt <= w_matchNext;
            end
          end else begin
            r_matchCnt <= '0;
          end
        end
        ST_LOCKED: begin
          r_errBits <= w_errBits;
          r_errWord <= |w_errBits;
          // Reference free-runs while locked so a bit error never propagates.
          if (w_bad && (w_lossNext == LOSS_CNT)) begin
            r_state    <= ST_HUNT;
            r_locked   <= 1'b0;
            r_matchCnt <= '0;
            r_lossCnt  <= '0;
            r_ref      <= w_nextFromData;
          end else begin
            r_lossCnt <= w_bad ? w_lossNext : '0;
            r_ref     <= w_nextFromRef;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end else begin
      r_errWord <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errCnt <= '0;
      r_bitCnt <= '0;
    end else if (clear) begin
      r_errCnt <= '0;
      r_bitCnt <= '0;
    end else if (en && (r_state == ST_LOCKED)) begin
      r_errCnt <= w_errSum[CNT_W] ? '1 : w_errSum[CNT_W-1:0];
      r_bitCnt <= w_bitSum[CNT_W] ? '1 : w_bitSum[CNT_W-1:0];
    end
  end

  assign locked   = r_locked;
  assign err_word = r_errWord;
  assign err_bits = r_errBits;
  assign err_cnt  = r_errCnt;
  assign bit_cnt  = r_bitCnt;

endmodule

// File: tb/tb_prbs_wide_check.sv
// Self-checking bench for prbs_wide_check: directed vector table, hand-written
// corner sequences and a randomized run against a bit-stream reference model.
module tb_prbs_wide_check;

  localparam int WIDTH      = 8;
  localparam int LOCK_WORDS = 4;
  localparam int LOSS_WORDS = 4;
  localparam int LOSS_BITS  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        clear;
  logic [7:0]  dataIn;

  logic        locked, errWord;
  logic [3:0]  errBits;
  logic [31:0] errCnt, bitCnt;
  logic        locked8, errWord8;
  logic [3:0]  errBits8;
  logic [7:0]  errCnt8, bitCnt8;

  always #5 clk = ~clk;

  prbs_wide_check #(.WIDTH(8), .TAP1(6), .TAP2(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .data_in(dataIn), .clear(clear),
    .locked(locked), .err_word(errWord), .err_bits(errBits),
    .err_cnt(errCnt), .bit_cnt(bitCnt)
  );

  prbs_wide_check #(.WIDTH(8), .TAP1(6), .TAP2(5), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .data_in(dataIn), .clear(clear),
    .locked(locked8), .err_word(errWord8), .err_bits(errBits8),
    .err_cnt(errCnt8), .bit_cnt(bitCnt8)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed in terms of the bit stream.
  bit         mHunting;
  logic [7:0] mPred;
  int         mMatch, mLoss, mErrBits;
  bit         mLocked, mErrWord;
  longint     mErrCnt, mBitCnt, mErrCnt8, mBitCnt8;
  logic [7:0] genWord;

  typedef struct {
    logic [7:0] flip;
    logic       expLocked;
    logic       expErrWord;
    int         expErrBits;
    int         expErrCnt;
    int         expBitCnt;
  } vec_t;

  vec_t vecs[8];

  // Next word of the stream defined by b[n] = b[n-7] ^ b[n-6], MSB first.
  function automatic logic [7:0] nextWord(input logic [7:0] w);
    bit b[16];
    logic [7:0] r;
    for (int i = 0; i < 8; i++) b[i] = w[7-i];
    for (int n = 8; n < 16; n++) b[n] = b[n-7] ^ b[n-6];
    for (int i = 0; i < 8; i++) r[7-i] = b[8+i];
    return r;
  endfunction

  function automatic longint satAdd(input longint v, input longint a, input int w);
    longint maxV;
    maxV = (longint'(1) << w) - 1;
    return (v + a > maxV) ? maxV : v + a;
  endfunction

  task automatic modelReset();
    mHunting = 1'b1; mPred = 8'h00; mMatch = 0; mLoss = 0; mErrBits = 0;
    mLocked = 1'b0; mErrWord = 1'b0;
    mErrCnt = 0; mBitCnt = 0; mErrCnt8 = 0; mBitCnt8 = 0;
  endtask

  task automatic modelStep(input bit e, input logic [7:0] d, input bit c);
    int nerr;
    bit acc;
    nerr = 0;
    acc  = 1'b0;
    if (e) begin
      if (mHunting) begin
        if (d == mPred && d != 8'h00) mMatch++;
        else mMatch = 0;
        mPred    = nextWord(d);
        mErrWord = 1'b0;
        if (mMatch == LOCK_WORDS) begin
          mHunting = 1'b0; mLocked = 1'b1; mMatch = 0; mLoss = 0;
        end
      end else begin
        nerr     = $countones(d ^ mPred);
        acc      = 1'b1;
        mErrBits = nerr;
        mErrWord = (nerr != 0);
        mPred    = nextWord(mPred);
        if (nerr > LOSS_BITS) mLoss++;
        else mLoss = 0;
        if (mLoss == LOSS_WORDS) begin
          mHunting = 1'b1; mLocked = 1'b0; mMatch = 0; mLoss = 0;
          mPred = nextWord(d);
        end
      end
    end else begin
      mErrWord = 1'b0;
    end
    if (c) begin
      mErrCnt = 0; mBitCnt = 0; mErrCnt8 = 0; mBitCnt8 = 0;
    end else if (acc) begin
      mErrCnt  = satAdd(mErrCnt, nerr, 32);
      mBitCnt  = satAdd(mBitCnt, WIDTH, 32);
      mErrCnt8 = satAdd(mErrCnt8, nerr, 8);
      mBitCnt8 = satAdd(mBitCnt8, WIDTH, 8);
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".locked"},   64'(locked),   64'(mLocked));
    checkOutput({tag, ".errWord"},  64'(errWord),  64'(mErrWord));
    checkOutput({tag, ".errBits"},  64'(errBits),  64'(mErrBits));
    checkOutput({tag, ".errCnt"},   64'(errCnt),   64'(mErrCnt));
    checkOutput({tag, ".bitCnt"},   64'(bitCnt),   64'(mBitCnt));
    checkOutput({tag, ".locked8"},  64'(locked8),  64'(mLocked));
    checkOutput({tag, ".errWord8"}, 64'(errWord8), 64'(mErrWord));
    checkOutput({tag, ".errBits8"}, 64'(errBits8), 64'(mErrBits));
    checkOutput({tag, ".errCnt8"},  64'(errCnt8),  64'(mErrCnt8));
    checkOutput({tag, ".bitCnt8"},  64'(bitCnt8),  64'(mBitCnt8));
  endtask

  // Called at a negedge: drive, let the rising edge happen, check at next negedge.
  task automatic applyStimulus(input bit e, input logic [7:0] d, input bit c, input string tag);
    en = e; dataIn = d; clear = c;
    @(posedge clk);
    modelStep(e, d, c);
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic cleanWord(output logic [7:0] d);
    d = genWord;
    genWord = nextWord(genWord);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int n;
    int enabledWords;
    int lockAt;

    vecs[0] = '{8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 0, 0, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 0, 0, 0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 0, 0, 8};
    vecs[6] = '{8'h09, 1'b1, 1'b1, 2, 2, 16};
    vecs[7] = '{8'h00, 1'b1, 1'b0, 0, 2, 24};

    reset = 1'b1; en = 1'b0; clear = 1'b0; dataIn = 8'h00;
    modelReset();
    genWord = 8'h01;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset.locked",  64'(locked),  64'd0);
    checkOutput("reset.errWord", 64'(errWord), 64'd0);
    checkOutput("reset.errBits", 64'(errBits), 64'd0);
    checkOutput("reset.errCnt",  64'(errCnt),  64'd0);
    checkOutput("reset.bitCnt",  64'(bitCnt),  64'd0);

    checkOutput("stream.w1", 64'(genWord), 64'h01);
    checkOutput("stream.w2", 64'(nextWord(genWord)), 64'h06);
    checkOutput("stream.w3", 64'(nextWord(nextWord(genWord))), 64'h14);

    for (int i = 0; i < 8; i++) begin
      cleanWord(d);
      applyStimulus(1'b1, d ^ vecs[i].flip, 1'b0, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.tLocked", i),  64'(locked),  64'(vecs[i].expLocked));
      checkOutput($sformatf("vec%0d.tErrWord", i), 64'(errWord), 64'(vecs[i].expErrWord));
      checkOutput($sformatf("vec%0d.tErrBits", i), 64'(errBits), 64'(vecs[i].expErrBits));
      checkOutput($sformatf("vec%0d.tErrCnt", i),  64'(errCnt),  64'(vecs[i].expErrCnt));
      checkOutput($sformatf("vec%0d.tBitCnt", i),  64'(bitCnt),  64'(vecs[i].expBitCnt));
    end

    for (int i = 0; i < 100; i++) begin
      cleanWord(d);
      applyStimulus(1'b1, d, 1'b0, "clean100");
    end
    checkOutput("clean100.errCnt", 64'(errCnt), 64'd2);
    checkOutput("clean100.bitCnt", 64'(bitCnt), 64'd824);

    applyStimulus(1'b0, 8'h00, 1'b1, "clear");
    for (int i = 0; i < 4; i++) begin
      cleanWord(d);
      applyStimulus(1'b1, ~d, 1'b0, "invert");
    end
    checkOutput("loss.locked", 64'(locked), 64'd0);
    checkOutput("loss.errCnt", 64'(errCnt), 64'd32);
    checkOutput("loss.bitCnt", 64'(bitCnt), 64'd32);
    n = 0;
    while (!locked && n < 8) begin
      cleanWord(d);
      applyStimulus(1'b1, d, 1'b0, "relock");
      n++;
    end
    checkOutput("relock.words", 64'(n), 64'd5);
    checkOutput("relock.errCnt", 64'(errCnt), 64'd32);

    pulseReset();
    genWord = 8'h3C;
    enabledWords = 0;
    lockAt = -1;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        cleanWord(d);
        applyStimulus(1'b1, d, 1'b0, "toggle");
        enabledWords++;
      end else begin
        applyStimulus(1'b0, 8'($urandom), 1'b0, "toggle");
      end
      if (locked && lockAt < 0) lockAt = enabledWords;
    end
    checkOutput("toggle.lockAt", 64'(lockAt), 64'd5);
    checkOutput("toggle.bitCnt", 64'(bitCnt), 64'd40);

    applyStimulus(1'b0, 8'h00, 1'b1, "satClear");
    for (int i = 0; i < 40; i++) begin
      cleanWord(d);
      applyStimulus(1'b1, d, 1'b0, "satBits");
    end
    checkOutput("sat.bitCnt8", 64'(bitCnt8), 64'hFF);
    for (int i = 0; i < 130; i++) begin
      cleanWord(d);
      applyStimulus(1'b1, d ^ 8'h81, 1'b0, "satErr");
    end
    checkOutput("sat.errCnt8", 64'(errCnt8), 64'hFF);
    checkOutput("sat.errCnt",  64'(errCnt),  64'd260);
    checkOutput("sat.locked",  64'(locked),  64'd1);
    cleanWord(d);
    applyStimulus(1'b1, d ^ 8'h18, 1'b1, "clearWins");
    checkOutput("clearWins.errCnt",  64'(errCnt),  64'd0);
    checkOutput("clearWins.bitCnt",  64'(bitCnt),  64'd0);
    checkOutput("clearWins.errCnt8", 64'(errCnt8), 64'd0);
    checkOutput("clearWins.bitCnt8", 64'(bitCnt8), 64'd0);

    for (int i = 0; i < 600; i++) begin
      int r;
      logic e, c;
      e = ($urandom % 8) != 0;
      c = ($urandom % 50) == 0;
      if (e) begin
        r = $urandom % 100;
        if (r < 3) genWord = 8'($urandom_range(1, 255));
        cleanWord(d);
        if (r >= 3 && r < 13) d = d ^ (8'h01 << ($urandom % 8));
        else if (r >= 13 && r < 18) d = d ^ 8'($urandom);
        else if (r >= 18 && r < 22) d = ~d;
      end else begin
        d = 8'($urandom);
      end
      applyStimulus(e, d, c, "rand");
    end

    n = 0;
    while (!locked && n < 40) begin
      cleanWord(d);
      applyStimulus(1'b1, d, 1'b0, "prelock");
      n++;
    end
    checkOutput("prelock.locked", 64'(locked), 64'd1);
    cleanWord(d);
    en = 1'b1; dataIn = d ^ 8'h01; clear = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("asyncReset.locked",  64'(locked),  64'd0);
    checkOutput("asyncReset.errWord", 64'(errWord), 64'd0);
    checkOutput("asyncReset.errBits", 64'(errBits), 64'd0);
    checkOutput("asyncReset.errCnt",  64'(errCnt),  64'd0);
    checkOutput("asyncReset.bitCnt",  64'(bitCnt),  64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'h00, 1'b0, "zeros");
    end
    checkOutput("zeros.locked", 64'(locked), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
